// File: rtl/kiwi_stream_arbiter.sv
// kiwi_stream_arbiter
//   Round-robin arbiter merging three AXI-Stream sources (RX, WF0, WF1) onto
//   one AXI-Stream master in fixed-length bursts. A source that has been
//   granted keeps the output for cfg_burst words, with 0 treated as 1. Between
//   bursts there is always one IDLE cycle used for arbitration.
//
// Ports
//   aclk, areset          clock; asynchronous active-high reset
//   cfg_enable[2:0]       per-source enable (bit0 RX, bit1 WF0, bit2 WF1)
//   cfg_burst             words per grant, sampled when the grant is taken
//   s_axis_rx_*           RX source stream   (tdata/tvalid in, tready out)
//   s_axis_wf0_*          WF0 source stream
//   s_axis_wf1_*          WF1 source stream
//   m_axis_*              merged output; tuser is the source id, tlast ends a burst
//   sts_busy              high while a burst is in progress
//   sts_bursts            per-source count of completed bursts, RX in the LSBs
module kiwi_stream_arbiter #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH       = 16
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic [2:0]                  cfg_enable,
   input  logic [CNTR_WIDTH-1:0]       cfg_burst,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_rx_tdata,
   input  logic                        s_axis_rx_tvalid,
   output logic                        s_axis_rx_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_wf0_tdata,
   input  logic                        s_axis_wf0_tvalid,
   output logic                        s_axis_wf0_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_wf1_tdata,
   input  logic                        s_axis_wf1_tvalid,
   output logic                        s_axis_wf1_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic [1:0]                  m_axis_tuser,
   output logic                        sts_busy,
   output logic [3*CNTR_WIDTH-1:0]     sts_bursts
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

   logic [0:0]            state_reg;
   logic [1:0]            grant_reg;
   logic [1:0]            last_reg;
   logic [CNTR_WIDTH-1:0] cnt_reg;

   logic [2:0]            src_valid;
   logic [2:0]            src_ready;
   logic [3:0]            eligible;
   logic [1:0]            cand1, cand2, cand3;
   logic                  pick_valid;
   logic [1:0]            pick;
   logic                  sel_valid;
   logic [AXIS_TDATA_WIDTH-1:0] sel_data;
   logic                  fire;
   logic                  done;
   logic [CNTR_WIDTH-1:0] burst_load;

   assign src_valid = {s_axis_wf1_tvalid, s_axis_wf0_tvalid, s_axis_rx_tvalid};

   // Top bit pads the vector so a 2-bit index can never fall outside it.
   assign eligible  = {1'b0, cfg_enable & src_valid};

   // Source id after s, wrapping WF1 -> RX.
   function automatic logic [1:0] rr_next(input logic [1:0] s);
      return (s >= 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   // Search order starts just after the last granted source; the last granted
   // source itself is considered only when nobody else is eligible.
   assign cand1 = rr_next(last_reg);
   assign cand2 = rr_next(cand1);
   assign cand3 = rr_next(cand2);

   always_comb begin
      pick_valid = 1'b1;
      pick       = cand1;
      if (eligible[cand1]) begin
         pick = cand1;
      end else if (eligible[cand2]) begin
         pick = cand2;
      end else if (eligible[cand3]) begin
         pick = cand3;
      end else begin
         pick_valid = 1'b0;
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      case (grant_reg)
         2'd0: begin sel_valid = s_axis_rx_tvalid;  sel_data = s_axis_rx_tdata;  end
         2'd1: begin sel_valid = s_axis_wf0_tvalid; sel_data = s_axis_wf0_tdata; end
         2'd2: begin sel_valid = s_axis_wf1_tvalid; sel_data = s_axis_wf1_tdata; end
         default: begin sel_valid = 1'b0; sel_data = '0; end
      endcase
   end

   assign sts_busy      = (state_reg == XFER);
   assign m_axis_tvalid = sts_busy & sel_valid;
   assign m_axis_tdata  = sts_busy ? sel_data : '0;
   assign m_axis_tuser  = sts_busy ? grant_reg : 2'd0;
   assign m_axis_tlast  = m_axis_tvalid & (cnt_reg == CNT_ONE);

   assign fire       = m_axis_tvalid & m_axis_tready;
   assign done       = fire & m_axis_tlast;
   assign burst_load = (cfg_burst == '0) ? CNT_ONE : cfg_burst;

   assign s_axis_rx_tready  = src_ready[0];
   assign s_axis_wf0_tready = src_ready[1];
   assign s_axis_wf1_tready = src_ready[2];

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_reg <= IDLE;
         grant_reg <= 2'd0;
         last_reg  <= 2'd2;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pick_valid) begin
                  state_reg <= XFER;
                  grant_reg <= pick;
                  cnt_reg   <= burst_load;
               end
            end
            XFER: begin
               if (fire) begin
                  cnt_reg <= cnt_reg - CNT_ONE;
                  if (cnt_reg == CNT_ONE) begin
                     state_reg <= IDLE;
                     last_reg  <= grant_reg;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Per-source ready steering and completed-burst counters.
   for (genvar gi = 0; gi < 3; gi++) begin : g_src
      logic [CNTR_WIDTH-1:0] count_reg;

      assign src_ready[gi] = sts_busy & (grant_reg == 2'(gi)) & m_axis_tready;

      always_ff @(posedge aclk or posedge areset) begin
         if (areset) begin
            count_reg <= '0;
         end else if (done && (grant_reg == 2'(gi))) begin
            count_reg <= count_reg + CNT_ONE;
         end
      end

      assign sts_bursts[gi*CNTR_WIDTH +: CNTR_WIDTH] = count_reg;
   end

endmodule
